// File: rtl/culsans_snoop_collector.sv
// Snoop fan-out/fan-in: broadcasts one AC snoop, merges CR responses,
// forwards CD data from one responder and drains the redundant copies.
module culsans_snoop_collector #(
  parameter int unsigned NumPorts     = 2,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned BeatsPerLine = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ac_valid_i,
  output logic                          ac_ready_o,
  input  logic [AddrWidth-1:0]          ac_addr_i,
  input  logic [3:0]                    ac_snoop_i,
  input  logic [2:0]                    ac_prot_i,
  input  logic [NumPorts-1:0]           ac_mask_i,
  output logic [NumPorts-1:0]           snp_ac_valid_o,
  input  logic [NumPorts-1:0]           snp_ac_ready_i,
  output logic [AddrWidth-1:0]          snp_ac_addr_o,
  output logic [3:0]                    snp_ac_snoop_o,
  output logic [2:0]                    snp_ac_prot_o,
  input  logic [NumPorts-1:0]           snp_cr_valid_i,
  output logic [NumPorts-1:0]           snp_cr_ready_o,
  input  logic [5*NumPorts-1:0]         snp_cr_resp_i,
  input  logic [NumPorts-1:0]           snp_cd_valid_i,
  output logic [NumPorts-1:0]           snp_cd_ready_o,
  input  logic [DataWidth*NumPorts-1:0] snp_cd_data_i,
  input  logic [NumPorts-1:0]           snp_cd_last_i,
  output logic                          cr_valid_o,
  input  logic                          cr_ready_i,
  output logic [4:0]                    cr_resp_o,
  output logic                          cd_valid_o,
  input  logic                          cd_ready_i,
  output logic [DataWidth-1:0]          cd_data_o,
  output logic                          cd_last_o
);

  localparam int unsigned SelW =
    (NumPorts > 1) ? $clog2(NumPorts) : 1;

  if (BeatsPerLine == 0) begin : g_bad_line
    $error("BeatsPerLine must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE,
    SEND_AC,
    WAIT_CR,
    SEND_CR,
    FWD_CD
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [3:0]            snoop_q, snoop_d;
  logic [2:0]            prot_q, prot_d;
  logic [NumPorts-1:0]   mask_q, mask_d;
  logic [NumPorts-1:0]   pend_ac_q, pend_ac_d;
  logic [NumPorts-1:0]   pend_cr_q, pend_cr_d;
  logic [NumPorts-1:0]   dt_q, dt_d;
  logic [NumPorts-1:0]   drain_q, drain_d;
  logic [4:0]            resp_q, resp_d;
  logic                  fwd_done_q, fwd_done_d;
  logic                  run_q;

  logic [SelW-1:0]       sel;
  logic [NumPorts-1:0]   sel_oh;
  logic [NumPorts-1:0]   ac_done;
  logic [NumPorts-1:0]   ac_hs;
  logic [NumPorts-1:0]   cr_hs;
  logic                  fwd_last_hs;

  assign snp_ac_addr_o  = addr_q;
  assign snp_ac_snoop_o = snoop_q;
  assign snp_ac_prot_o  = prot_q;
  assign cr_resp_o      = resp_q;
  assign ac_done        = mask_q & ~pend_ac_q;

  // lowest-index data responder supplies the line
  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (dt_q[i]) sel = SelW'(i);
    end
    sel_oh[sel] = dt_q[sel];
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    snoop_d        = snoop_q;
    prot_d         = prot_q;
    mask_d         = mask_q;
    pend_ac_d      = pend_ac_q;
    pend_cr_d      = pend_cr_q;
    dt_d           = dt_q;
    drain_d        = drain_q;
    resp_d         = resp_q;
    fwd_done_d     = fwd_done_q;
    ac_ready_o     = 1'b0;
    snp_ac_valid_o = '0;
    snp_cr_ready_o = '0;
    snp_cd_ready_o = '0;
    cr_valid_o     = 1'b0;
    cd_valid_o     = 1'b0;
    cd_data_o      = '0;
    cd_last_o      = 1'b0;
    ac_hs          = '0;
    cr_hs          = '0;
    fwd_last_hs    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ac_ready_o = run_q;
        if (ac_valid_i && run_q) begin
          addr_d     = ac_addr_i;
          snoop_d    = ac_snoop_i;
          prot_d     = ac_prot_i;
          mask_d     = ac_mask_i;
          pend_ac_d  = ac_mask_i;
          pend_cr_d  = ac_mask_i;
          dt_d       = '0;
          drain_d    = '0;
          resp_d     = '0;
          fwd_done_d = 1'b0;
          state_d    = (ac_mask_i == '0) ? SEND_CR : SEND_AC;
        end
      end
      SEND_AC, WAIT_CR: begin
        snp_ac_valid_o = pend_ac_q;
        snp_cr_ready_o = pend_cr_q & ac_done;
        ac_hs          = snp_ac_valid_o & snp_ac_ready_i;
        cr_hs          = snp_cr_valid_i & snp_cr_ready_o;
        pend_ac_d      = pend_ac_q & ~ac_hs;
        pend_cr_d      = pend_cr_q & ~cr_hs;
        for (int i = 0; i < int'(NumPorts); i++) begin
          if (cr_hs[i]) begin
            resp_d  = resp_d | snp_cr_resp_i[5*i +: 5];
            dt_d[i] = snp_cr_resp_i[5*i];
          end
        end
        if (state_q == SEND_AC) begin
          if (pend_ac_d == '0) state_d = WAIT_CR;
        end else if (pend_cr_d == '0) begin
          state_d = SEND_CR;
        end
      end
      SEND_CR: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          drain_d = dt_q & ~sel_oh;
          state_d = (dt_q != '0) ? FWD_CD : IDLE;
        end
      end
      FWD_CD: begin
        snp_cd_ready_o = drain_q;
        drain_d = drain_q & ~(snp_cd_valid_i & snp_cd_last_i);
        if (!fwd_done_q) begin
          cd_valid_o          = snp_cd_valid_i[sel];
          cd_data_o           = snp_cd_data_i[DataWidth*sel +: DataWidth];
          cd_last_o           = snp_cd_last_i[sel];
          snp_cd_ready_o[sel] = cd_ready_i;
          fwd_last_hs         = cd_valid_o & cd_ready_i & cd_last_o;
        end
        fwd_done_d = fwd_done_q | fwd_last_hs;
        if (fwd_done_d && drain_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      snoop_q    <= '0;
      prot_q     <= '0;
      mask_q     <= '0;
      pend_ac_q  <= '0;
      pend_cr_q  <= '0;
      dt_q       <= '0;
      drain_q    <= '0;
      resp_q     <= '0;
      fwd_done_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      snoop_q    <= snoop_d;
      prot_q     <= prot_d;
      mask_q     <= mask_d;
      pend_ac_q  <= pend_ac_d;
      pend_cr_q  <= pend_cr_d;
      dt_q       <= dt_d;
      drain_q    <= drain_d;
      resp_q     <= resp_d;
      fwd_done_q <= fwd_done_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_culsans_snoop_collector.sv
// Bench for culsans_snoop_collector: directed scenarios plus random
// snoops, all checked against a transaction-level port model.
module tb_culsans_snoop_collector;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BL = 2;

  logic clk = 1'b0;
  logic rst_ni;
  logic ac_valid_i, ac_ready_o;
  logic [AW-1:0] ac_addr_i, snp_ac_addr_o;
  logic [3:0] ac_snoop_i, snp_ac_snoop_o;
  logic [2:0] ac_prot_i, snp_ac_prot_o;
  logic [NP-1:0] ac_mask_i;
  logic [NP-1:0] snp_ac_valid_o, snp_ac_ready_i;
  logic [NP-1:0] snp_cr_valid_i, snp_cr_ready_o;
  logic [5*NP-1:0] snp_cr_resp_i;
  logic [NP-1:0] snp_cd_valid_i, snp_cd_ready_o;
  logic [DW*NP-1:0] snp_cd_data_i;
  logic [NP-1:0] snp_cd_last_i;
  logic cr_valid_o, cr_ready_i;
  logic [4:0] cr_resp_o;
  logic cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0] cd_data_o;

  culsans_snoop_collector #(
    .NumPorts(NP), .AddrWidth(AW),
    .DataWidth(DW), .BeatsPerLine(BL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
    .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .ac_prot_i(ac_prot_i), .ac_mask_i(ac_mask_i),
    .snp_ac_valid_o(snp_ac_valid_o),
    .snp_ac_ready_i(snp_ac_ready_i),
    .snp_ac_addr_o(snp_ac_addr_o),
    .snp_ac_snoop_o(snp_ac_snoop_o),
    .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i),
    .snp_cr_ready_o(snp_cr_ready_o),
    .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i),
    .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data_i),
    .snp_cd_last_i(snp_cd_last_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
    .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
    .cd_data_o(cd_data_o), .cd_last_o(cd_last_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NP-1:0] t_mask;
  logic [4:0]    t_resp [NP];
  int            t_acd [NP];
  int            t_crd [NP];
  int            t_cdd [NP];
  logic [DW-1:0] t_data [NP][BL];
  int            t_crr;
  bit            t_cdrand, t_hold, t_rst;
  logic [AW-1:0] t_addr;
  logic [3:0]    t_snoop;
  logic [2:0]    t_prot;
  int            n_fwd;

  task automatic idle_drive();
    ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0;
    ac_prot_i = '0; ac_mask_i = '0;
    snp_ac_ready_i = '0; snp_cr_valid_i = '0;
    snp_cr_resp_i = '0; snp_cd_valid_i = '0;
    snp_cd_data_i = '0; snp_cd_last_i = '0;
    cr_ready_i = 0; cd_ready_i = 0;
  endtask

  task automatic set_defaults();
    t_mask = '1; t_crr = 0;
    t_cdrand = 0; t_hold = 0; t_rst = 0;
    t_addr = {$urandom, $urandom};
    t_snoop = 4'($urandom); t_prot = 3'($urandom);
    for (int i = 0; i < NP; i++) begin
      t_resp[i] = '0; t_acd[i] = 0;
      t_crd[i] = 1; t_cdd[i] = 0;
      for (int b = 0; b < BL; b++) t_data[i][b] = {$urandom, $urandom};
    end
  endtask

  task automatic check_all_zero(string tag);
    checks++;
    if ({ac_ready_o, snp_ac_valid_o, snp_cr_ready_o, snp_cd_ready_o,
         cr_valid_o, cd_valid_o, cd_last_o} !== '0) begin
      errors++;
      $display("FAIL %s ctl got %b exp 0", tag,
        {ac_ready_o, snp_ac_valid_o, snp_cr_ready_o, snp_cd_ready_o,
         cr_valid_o, cd_valid_o, cd_last_o});
    end
    checks++;
    if ({snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o,
         cr_resp_o, cd_data_o} !== '0) begin
      errors++;
      $display("FAIL %s payload got nonzero exp 0", tag);
    end
  endtask

  task automatic run_snoop(string tag);
    bit acd [NP]; bit crd [NP]; int beat [NP];
    bit crout, done, allcr, dv, cv, ouths;
    int cyc, crv, sel;
    logic [4:0] er;
    logic [NP-1:0] dt, exp_acv, exp_crr, exp_cdr, achs, crhs, cdhs;
    logic exp_crv, exp_cdv;
    er = '0; dt = '0; sel = -1;
    for (int i = 0; i < NP; i++)
      if (t_mask[i]) begin
        er |= t_resp[i];
        dt[i] = t_resp[i][0];
      end
    for (int i = NP - 1; i >= 0; i--) if (dt[i]) sel = i;
    @(negedge clk);
    ac_valid_i = 1; ac_addr_i = t_addr; ac_snoop_i = t_snoop;
    ac_prot_i = t_prot; ac_mask_i = t_mask;
    cyc = 0;
    while (!ac_ready_o && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (ac_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ac_ready got %b exp 1", tag, ac_ready_o);
      return;
    end
    @(posedge clk);
    for (int i = 0; i < NP; i++) begin
      acd[i] = 0; crd[i] = 0; beat[i] = 0;
    end
    crout = 0; done = 0; cyc = 0; crv = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (!t_hold) ac_valid_i = 0;
      for (int i = 0; i < NP; i++) begin
        snp_ac_ready_i[i] = (cyc >= t_acd[i]);
        cv = acd[i] && !crd[i] && cyc >= t_crd[i];
        snp_cr_valid_i[i] = cv;
        snp_cr_resp_i[5*i +: 5] = cv ? t_resp[i] : 5'($urandom);
        dv = crd[i] && dt[i] && beat[i] < BL && cyc >= t_cdd[i];
        snp_cd_valid_i[i] = dv;
        snp_cd_last_i[i] = dv && beat[i] == BL - 1;
        if (dv) snp_cd_data_i[DW*i +: DW] = t_data[i][beat[i]];
        else snp_cd_data_i[DW*i +: DW] = {$urandom, $urandom};
      end
      cr_ready_i = (crv >= t_crr);
      cd_ready_i = t_cdrand ? 1'($urandom) : 1'b1;
      if (t_rst && crout) begin
        rst_ni = 0;
        #1;
        check_all_zero({tag, "_async_rst"});
        idle_drive();
        @(negedge clk); @(negedge clk);
        rst_ni = 1;
        @(negedge clk); @(negedge clk);
        return;
      end
      #1;
      allcr = 1;
      exp_acv = '0; exp_crr = '0; exp_cdr = '0;
      for (int i = 0; i < NP; i++) begin
        exp_acv[i] = t_mask[i] && !acd[i];
        exp_crr[i] = acd[i] && !crd[i];
        if (t_mask[i] && !crd[i]) allcr = 0;
        if (crout && dt[i] && beat[i] < BL)
          exp_cdr[i] = (i == sel) ? cd_ready_i : 1'b1;
      end
      exp_crv = allcr && !crout;
      exp_cdv = 0;
      if (crout && sel >= 0)
        exp_cdv = beat[sel] < BL && snp_cd_valid_i[sel];
      checks++;
      if (ac_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s ac_ready_busy got %b exp 0", tag, ac_ready_o);
      end
      checks++;
      if ({snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o} !==
          {t_addr, t_snoop, t_prot}) begin
        errors++;
        $display("FAIL %s ac_payload got %h exp %h", tag,
          snp_ac_addr_o, t_addr);
      end
      checks++;
      if (snp_ac_valid_o !== exp_acv) begin
        errors++;
        $display("FAIL %s snp_ac_valid got %b exp %b", tag,
          snp_ac_valid_o, exp_acv);
      end
      checks++;
      if (snp_cr_ready_o !== exp_crr) begin
        errors++;
        $display("FAIL %s snp_cr_ready got %b exp %b", tag,
          snp_cr_ready_o, exp_crr);
      end
      checks++;
      if (cr_valid_o !== exp_crv) begin
        errors++;
        $display("FAIL %s cr_valid got %b exp %b", tag,
          cr_valid_o, exp_crv);
      end
      if (exp_crv) begin
        checks++;
        if (cr_resp_o !== er) begin
          errors++;
          $display("FAIL %s cr_resp got %b exp %b", tag, cr_resp_o, er);
        end
      end
      checks++;
      if (snp_cd_ready_o !== exp_cdr) begin
        errors++;
        $display("FAIL %s snp_cd_ready got %b exp %b", tag,
          snp_cd_ready_o, exp_cdr);
      end
      checks++;
      if (cd_valid_o !== exp_cdv) begin
        errors++;
        $display("FAIL %s cd_valid got %b exp %b", tag,
          cd_valid_o, exp_cdv);
      end
      if (exp_cdv) begin
        checks++;
        if ({cd_data_o, cd_last_o} !==
            {t_data[sel][beat[sel]], 1'(beat[sel] == BL - 1)}) begin
          errors++;
          $display("FAIL %s cd_beat got %h/%b exp %h beat %0d", tag,
            cd_data_o, cd_last_o, t_data[sel][beat[sel]], beat[sel]);
        end
      end
      achs = snp_ac_valid_o & snp_ac_ready_i;
      crhs = snp_cr_valid_i & snp_cr_ready_o;
      cdhs = snp_cd_valid_i & snp_cd_ready_o;
      ouths = cr_valid_o & cr_ready_i;
      if (cd_valid_o && cd_ready_i) n_fwd++;
      @(posedge clk);
      for (int i = 0; i < NP; i++) begin
        if (achs[i]) acd[i] = 1;
        if (crhs[i]) crd[i] = 1;
        if (cdhs[i]) beat[i]++;
      end
      if (exp_crv && !ouths) crv++;
      if (ouths) crout = 1;
      done = crout;
      for (int i = 0; i < NP; i++)
        if (dt[i] && beat[i] < BL) done = 0;
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got busy exp done", tag);
    end
    @(negedge clk);
    idle_drive();
    #1;
    checks++;
    if ({ac_ready_o, cr_valid_o, cd_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL %s end_idle got %b exp 100", tag,
        {ac_ready_o, cr_valid_o, cd_valid_o});
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle_drive();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (ac_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", ac_ready_o);
    end
  endtask

  task automatic test_shared();
    set_defaults();
    t_resp[0] = 5'b01000; t_resp[1] = 5'b01000;
    n_fwd = 0;
    run_snoop("shared");
    checks++;
    if (n_fwd !== 0) begin
      errors++;
      $display("FAIL shared_cd got %0d beats exp 0", n_fwd);
    end
  endtask

  task automatic test_dirty_fwd();
    set_defaults();
    t_resp[1] = 5'b00101;
    t_data[1][0] = 64'hA5A5_A5A5_A5A5_A5A5;
    t_data[1][1] = 64'h5A5A_5A5A_5A5A_5A5A;
    t_cdd[1] = 2;
    n_fwd = 0;
    run_snoop("dirty_fwd");
    checks++;
    if (n_fwd !== 2) begin
      errors++;
      $display("FAIL dirty_fwd_beats got %0d exp 2", n_fwd);
    end
  endtask

  task automatic test_drain();
    set_defaults();
    t_resp[0] = 5'b00001; t_resp[1] = 5'b00001;
    t_data[0][0] = 64'h11; t_data[0][1] = 64'h22;
    t_data[1][0] = 64'h33; t_data[1][1] = 64'h44;
    t_cdd[0] = 6;
    n_fwd = 0;
    run_snoop("drain");
    checks++;
    if (n_fwd !== 2) begin
      errors++;
      $display("FAIL drain_beats got %0d exp 2", n_fwd);
    end
  endtask

  task automatic test_mask_zero();
    set_defaults();
    t_mask = '0;
    t_resp[0] = 5'b11111; t_resp[1] = 5'b11111;
    run_snoop("mask_zero");
  endtask

  task automatic test_backpressure();
    set_defaults();
    t_resp[0] = 5'b10000; t_resp[1] = 5'b01000;
    t_acd[1] = 5; t_crr = 3; t_hold = 1;
    t_crd[0] = 1; t_crd[1] = 7;
    run_snoop("backpressure");
  endtask

  task automatic test_reset_fwd();
    set_defaults();
    t_resp[0] = 5'b00001; t_resp[1] = 5'b00101;
    t_rst = 1;
    run_snoop("rst_fwd");
    set_defaults();
    t_resp[0] = 5'b00101; t_resp[1] = 5'b00001;
    t_cdrand = 1;
    run_snoop("after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      set_defaults();
      t_mask = NP'($urandom);
      t_crr = $urandom_range(0, 3);
      t_cdrand = 1;
      t_hold = 1'($urandom);
      for (int i = 0; i < NP; i++) begin
        t_resp[i] = 5'($urandom);
        t_acd[i] = $urandom_range(0, 4);
        t_crd[i] = $urandom_range(0, 6);
        t_cdd[i] = $urandom_range(0, 5);
      end
      run_snoop("random");
    end
  endtask

  initial begin
    test_reset();
    test_shared();
    test_dirty_fwd();
    test_drain();
    test_mask_zero();
    test_backpressure();
    test_reset_fwd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
